// File: rtl/mux41_scan_ctrl_pkg.sv
// Shared constants and state encoding for the mux41 scan sequencer.
package mux41_scan_ctrl_pkg;

  localparam int NCH   = 4;
  localparam int SEL_W = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    HOLD   = 2'd3
  } state_t;

endpackage

// File: rtl/mux41.sv
// 4:1 data mux selected by the scan sequencer.
// Latency: combinational. Backpressure: none.
// Output y follows a[sel] within the same cycle.
module mux41 (
  input  logic [3:0] a,
  input  logic [1:0] sel,
  output logic       y
);

  assign y = a[sel];

endmodule

// File: rtl/mux41_dwell_timer.sv
// Down-counter that measures the per-channel settle time.
// Latency: load takes effect at the next edge; done is a decode of the count.
// Backpressure: none, counts down freely and parks at zero.
module mux41_dwell_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             done
);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  assign done = (cnt_q == '0);

endmodule

// File: rtl/mux41_scan_ctrl.sv
// Scans the four mux41 channels, captures y per channel into a 4-bit word.
// Latency: word_valid rises 4*(DWELL+1) edges after start is accepted.
// Backpressure: word is held in HOLD until word_valid & word_ready.
module mux41_scan_ctrl
  import mux41_scan_ctrl_pkg::*;
#(
  parameter int DWELL = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             cont,
  input  logic             y,
  output logic [SEL_W-1:0] sel,
  output logic             busy,
  output logic [NCH-1:0]   word,
  output logic             word_valid,
  input  logic             word_ready
);

  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(DWELL - 1);
  localparam logic [SEL_W-1:0] LAST_CH  = SEL_W'(NCH - 1);

  state_t           state_q, state_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [NCH-1:0]   word_q, word_d;
  logic [NCH-1:0]   shreg_q, shreg_d;
  logic             wv_q, wv_d;
  logic             busy_q;
  logic             timer_load;
  logic             timer_done;

  mux41_dwell_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (timer_load),
    .load_val (LOAD_VAL),
    .done     (timer_done)
  );

  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    word_d     = word_q;
    wv_d       = wv_q;
    shreg_d    = shreg_q;
    timer_load = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = SETTLE;
          sel_d      = '0;
          shreg_d    = '0;
          timer_load = 1'b1;
        end
      end
      SETTLE: begin
        if (timer_done) state_d = SAMPLE;
      end
      SAMPLE: begin
        shreg_d[sel_q] = y;
        // The word published includes the bit sampled on this same edge.
        if (sel_q == LAST_CH) begin
          word_d  = shreg_d;
          wv_d    = 1'b1;
          state_d = HOLD;
        end else begin
          sel_d      = sel_q + SEL_W'(1);
          timer_load = 1'b1;
          state_d    = SETTLE;
        end
      end
      HOLD: begin
        if (word_ready) begin
          wv_d = 1'b0;
          if (cont) begin
            sel_d      = '0;
            shreg_d    = '0;
            timer_load = 1'b1;
            state_d    = SETTLE;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sel_q   <= '0;
      word_q  <= '0;
      shreg_q <= '0;
      wv_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      word_q  <= word_d;
      shreg_q <= shreg_d;
      wv_q    <= wv_d;
      busy_q  <= (state_d != IDLE);
    end
  end

  assign sel        = sel_q;
  assign busy       = busy_q;
  assign word       = word_q;
  assign word_valid = wv_q;

endmodule

// File: tb/tb_mux41_scan_ctrl.sv
// Closed-loop bench: mux41 feeds y back from sel; expected words go through a queue.
module tb_mux41_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       cont;
  logic       y;
  logic       word_ready;
  logic       word_valid;
  logic       busy;
  logic [1:0] sel;
  logic [3:0] word;
  logic [3:0] a;

  int         checks   = 0;
  int         failures = 0;
  logic [3:0] exp_q[$];

  mux41 u_mux (
    .a   (a),
    .sel (sel),
    .y   (y)
  );

  mux41_scan_ctrl #(
    .DWELL (4),
    .CNT_W (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .cont       (cont),
    .y          (y),
    .sel        (sel),
    .busy       (busy),
    .word       (word),
    .word_valid (word_valid),
    .word_ready (word_ready)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Counts edges until word_valid; n0 edges have already elapsed since the accepting edge.
  task automatic wait_valid(input string tag, input int n0);
    int n;
    n = n0;
    do begin
      tick();
      n++;
    end while (!word_valid && n < 60);
    chk(tag, 32'(n), 32'd20);
  endtask

  task automatic pop_check(input string tag);
    logic [3:0] e;
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $error("FAIL %s observed=%0h expected=<none queued>", tag, word);
    end else begin
      e = exp_q.pop_front();
      chk(tag, 32'(word), 32'(e));
    end
  endtask

  task automatic run_single(input logic [3:0] val, input string tag);
    a          = val;
    cont       = 1'b0;
    word_ready = 1'b1;
    exp_q.push_back(val);
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_valid({tag, "_lat"}, 0);
    pop_check({tag, "_word"});
    chk({tag, "_busy_hold"}, 32'(busy), 32'd1);
    tick();
    chk({tag, "_valid_after"}, 32'(word_valid), 32'd0);
    chk({tag, "_busy_after"}, 32'(busy), 32'd0);
    chk({tag, "_word_kept"}, 32'(word), 32'(val));
  endtask

  initial begin
    logic [3:0] old_a;
    logic [3:0] new_a;
    logic       seen;

    rst        = 1'b1;
    start      = 1'b0;
    cont       = 1'b0;
    word_ready = 1'b0;
    a          = 4'b0000;

    // Reset held for two edges
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("rst_sel", 32'(sel), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_word", 32'(word), 32'd0);
      chk("rst_valid", 32'(word_valid), 32'd0);
    end
    rst = 1'b0;
    tick();

    // Single scans with one-hot patterns
    run_single(4'b0100, "s_0100");
    run_single(4'b0001, "s_0001");
    run_single(4'b0010, "s_0010");
    run_single(4'b1000, "s_1000");

    // Consumer stalls in HOLD
    a          = 4'b1000;
    cont       = 1'b0;
    word_ready = 1'b0;
    exp_q.push_back(a);
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_valid("hold_lat", 0);
    pop_check("hold_word");
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("hold_word_stable", 32'(word), 32'b1000);
      chk("hold_valid_stable", 32'(word_valid), 32'd1);
    end
    word_ready = 1'b1;
    tick();
    chk("hold_release_valid", 32'(word_valid), 32'd0);
    chk("hold_release_busy", 32'(busy), 32'd0);

    // Continuous mode, data changes after channel 0 of the second scan was sampled
    old_a      = 4'b0001;
    new_a      = 4'b1000;
    a          = old_a;
    cont       = 1'b1;
    word_ready = 1'b1;
    exp_q.push_back(old_a);
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_valid("cont0_lat", 0);
    pop_check("cont0_word");
    exp_q.push_back((old_a & 4'b0001) | (new_a & 4'b1110));
    tick();
    chk("cont_hs_valid", 32'(word_valid), 32'd0);
    chk("cont_hs_busy", 32'(busy), 32'd1);
    chk("cont_hs_sel", 32'(sel), 32'd0);
    repeat (7) tick();
    a = new_a;
    wait_valid("cont1_lat", 7);
    pop_check("cont1_word");
    cont = 1'b0;
    tick();
    chk("cont_end_busy", 32'(busy), 32'd0);
    chk("cont_end_sel", 32'(sel), 32'd3);

    // Start pulses while busy are ignored
    a          = 4'b0010;
    cont       = 1'b0;
    word_ready = 1'b0;
    exp_q.push_back(a);
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_valid("busy_start_lat", 4);
    pop_check("busy_start_word");
    start = 1'b1;
    tick();
    tick();
    chk("hold_start_valid", 32'(word_valid), 32'd1);
    chk("hold_start_sel", 32'(sel), 32'd3);
    word_ready = 1'b1;
    tick();
    chk("hs_start_valid", 32'(word_valid), 32'd0);
    chk("hs_start_busy", 32'(busy), 32'd0);
    start = 1'b0;
    tick();
    chk("hs_start_idle", 32'(busy), 32'd0);

    // Reset during SETTLE of channel 2
    a          = 4'b1111;
    word_ready = 1'b1;
    start      = 1'b1;
    tick();
    start = 1'b0;
    repeat (12) tick();
    chk("abort_pre_sel", 32'(sel), 32'd2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_sel", 32'(sel), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_word", 32'(word), 32'd0);
    chk("abort_valid", 32'(word_valid), 32'd0);
    seen = 1'b0;
    for (int i = 0; i < 25; i++) begin
      tick();
      if (word_valid) seen = 1'b1;
    end
    chk("abort_no_valid", 32'(seen), 32'd0);
    run_single(4'b0010, "post_rst");

    chk("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
